result_reader: RTL and testbench

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_reader_pkg.sv | 16 +
 rtl/result_reader_sync_fifo.sv | 59 +++++
 rtl/result_reader.sv | 141 ++++++++++++++
 tb/tb_result_reader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_reader_pkg.sv
// Shared constants and state encoding for the DRAM result reader.
package result_reader_pkg;

    localparam int unsigned RR_ADDR_W     = 16;
    localparam int unsigned RR_DATA_W     = 8;
    localparam int unsigned RR_FIFO_DEPTH = 4;
    localparam int unsigned RR_COUNT_W    = 16;

    typedef logic [1:0] rr_state_t;

    localparam rr_state_t ST_IDLE  = 2'd0;
    localparam rr_state_t ST_READ  = 2'd1;
    localparam rr_state_t ST_DRAIN = 2'd2;
    localparam rr_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/result_reader_sync_fifo.sv
// Small synchronous FIFO; head is visible the cycle after a push (no bypass).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only legal when the head leaves on the same edge.
    assign do_pop  = i_pop && (count_q != '0);
    assign do_push = i_push && ((count_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= i_push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign o_head  = mem_q[rd_ptr_q];
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;

endmodule

// File: rtl/result_reader.sv
// Streams a block of DRAM results out through a ready/valid port, with
// credit-based read issue so the output FIFO can never overflow.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int unsigned ADDR_W     = RR_ADDR_W,
    parameter int unsigned DATA_W     = RR_DATA_W,
    parameter int unsigned FIFO_DEPTH = RR_FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_W-1:0]     i_base_addr,
    input  logic [RR_COUNT_W-1:0] i_count,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_dram_read,
    output logic [ADDR_W-1:0]     o_dram_addr,
    input  logic [DATA_W-1:0]     i_dram_data,
    output logic                  o_valid,
    output logic [DATA_W-1:0]     o_data,
    input  logic                  i_ready
);
    localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned CNT_W = RR_COUNT_W;

    rr_state_t          state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic               read_q, read_d;
    logic               inflight_q;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CW-1:0]      fifo_count;
    logic [DATA_W-1:0]  fifo_head;
    logic               pop;
    logic [CW:0]        occ;
    logic               credit_ok;

    assign pop = !fifo_empty && i_ready;

    // Slots already spoken for: buffered + returning next edge + strobed this cycle.
    assign occ       = (CW+1)'(fifo_count) + (CW+1)'(read_q) + (CW+1)'(inflight_q);
    assign credit_ok = !fifo_full && (occ < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        count_d  = count_q;
        issued_d = issued_q;
        read_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    count_d  = i_count;
                    issued_d = '0;
                    if (i_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d  = ST_READ;
                        read_d   = 1'b1;
                        addr_d   = i_base_addr;
                        issued_d = CNT_W'(1);
                    end
                end
            end
            ST_READ: begin
                if (read_q && (issued_q == count_q)) begin
                    state_d = ST_DRAIN;
                end else if ((issued_q < count_q) && credit_ok) begin
                    read_d   = 1'b1;
                    addr_d   = addr_q + ADDR_W'(1);
                    issued_d = issued_q + CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (!inflight_q && (fifo_empty || ((fifo_count == CW'(1)) && pop))) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // Clearing inflight on reset drops any DRAM beat still on its way back.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            read_q     <= 1'b0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            read_q     <= read_d;
            inflight_q <= read_q;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_push      (inflight_q),
        .i_push_data (i_dram_data),
        .i_pop       (pop),
        .o_head      (fifo_head),
        .o_full      (fifo_full),
        .o_empty     (fifo_empty),
        .o_count     (fifo_count)
    );

    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_dram_read = read_q;
    assign o_dram_addr = addr_q;
    assign o_valid     = !fifo_empty;
    assign o_data      = fifo_head;

endmodule

// File: tb/tb_result_reader.sv
// Scoreboard bench for result_reader: expected addresses/data queued at start,
// checked as strobes and stream transfers appear.
module tb_result_reader;

    localparam int unsigned DEPTH = 4;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [15:0] i_base_addr;
    logic [15:0] i_count;
    logic        o_busy;
    logic        o_done;
    logic        o_dram_read;
    logic [15:0] o_dram_addr;
    logic [7:0]  i_dram_data;
    logic        o_valid;
    logic [7:0]  o_data;
    logic        i_ready;

    int checks = 0;
    int passes = 0;

    logic [15:0] exp_addr_q[$];
    logic [7:0]  exp_data_q[$];
    logic [7:0]  dram_key = 8'h00;

    int obs_done;
    int obs_xfer;
    int obs_strobe_stall;

    result_reader dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_count     (i_count),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_dram_read (o_dram_read),
        .o_dram_addr (o_dram_addr),
        .i_dram_data (i_dram_data),
        .o_valid     (o_valid),
        .o_data      (o_data),
        .i_ready     (i_ready)
    );

    always #5 i_clk = ~i_clk;

    // DRAM model: one-cycle read latency, junk when no read was strobed.
    always @(posedge i_clk) begin
        if (o_dram_read === 1'b1) i_dram_data <= o_dram_addr[7:0] ^ dram_key;
        else                      i_dram_data <= 8'($urandom);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // mode 0: ready held high, 1: ready low for 20 cycles, 2: random ready + junk start
    task automatic run_readout(input logic [15:0] base, input logic [15:0] cnt,
                               input int mode, input logic [7:0] key);
        logic [15:0] a;
        logic [7:0]  d;
        logic        pv, pr;
        logic [7:0]  pd;
        int          cyc;
        bit          finished;
        for (int i = 0; i < int'(cnt); i++) begin
            a = base + 16'(i);
            exp_addr_q.push_back(a);
            exp_data_q.push_back(a[7:0] ^ key);
        end
        dram_key    = key;
        i_base_addr = base;
        i_count     = cnt;
        i_start     = 1'b1;
        @(posedge i_clk); #1;
        i_start     = 1'b0;
        i_base_addr = 16'hDEAD;
        i_count     = 16'd3;
        obs_done = 0; obs_xfer = 0; obs_strobe_stall = 0;
        pv = 1'b0; pr = 1'b0; pd = '0; finished = 0; cyc = 0;
        while (!finished && cyc < 3000) begin
            case (mode)
                0:       i_ready = 1'b1;
                1:       i_ready = (cyc >= 20);
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
            if (mode == 2 && o_busy && !o_done) begin
                i_start     = 1'($urandom_range(0, 1));
                i_base_addr = 16'($urandom);
                i_count     = 16'($urandom);
            end else begin
                i_start = 1'b0;
            end
            if (o_dram_read) begin
                if (mode == 1 && cyc < 20) obs_strobe_stall++;
                checks++;
                if (exp_addr_q.size() == 0) begin
                    $display("FAIL extra_strobe: addr %0h strobed, no strobe expected", o_dram_addr);
                end else begin
                    a = exp_addr_q.pop_front();
                    if (o_dram_addr !== a)
                        $display("FAIL strobe_addr: got %0h expected %0h", o_dram_addr, a);
                    else passes++;
                end
            end
            if (pv && !pr) begin
                checks++;
                if (o_valid !== 1'b1 || o_data !== pd)
                    $display("FAIL hold: valid=%0b data=%0h expected valid=1 data=%0h", o_valid, o_data, pd);
                else passes++;
            end
            if (o_valid && i_ready) begin
                obs_xfer++;
                checks++;
                if (exp_data_q.size() == 0) begin
                    $display("FAIL extra_element: got %0h, none expected", o_data);
                end else begin
                    d = exp_data_q.pop_front();
                    if (o_data !== d)
                        $display("FAIL stream_data: got %0h expected %0h", o_data, d);
                    else passes++;
                end
            end
            if (o_done) begin
                obs_done++;
                finished = 1;
                checks++;
                if (o_busy !== 1'b1 || exp_data_q.size() != 0 || exp_addr_q.size() != 0)
                    $display("FAIL done_state: busy=%0b left_data=%0d left_addr=%0d expected busy=1 0 0",
                             o_busy, exp_data_q.size(), exp_addr_q.size());
                else passes++;
            end
            pv = o_valid; pr = i_ready; pd = o_data;
            @(posedge i_clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        checks++;
        if (!finished) $display("FAIL timeout: no done after %0d cycles, expected done", cyc);
        else passes++;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0)
            $display("FAIL after_done: busy=%0b done=%0b expected 0 0", o_busy, o_done);
        else passes++;
        for (int k = 0; k < 3; k++) begin
            if (o_done) obs_done++;
            @(posedge i_clk); #1;
        end
        exp_addr_q.delete();
        exp_data_q.delete();
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0; i_start = 1'b0; i_ready = 1'b0;
        i_base_addr = '0; i_count = '0;
        repeat (3) @(posedge i_clk);
        #1;
        checks++; if (o_busy !== 1'b0) $display("FAIL rst_busy: got %0b expected 0", o_busy); else passes++;
        checks++; if (o_done !== 1'b0) $display("FAIL rst_done: got %0b expected 0", o_done); else passes++;
        checks++; if (o_dram_read !== 1'b0) $display("FAIL rst_read: got %0b expected 0", o_dram_read); else passes++;
        checks++; if (o_dram_addr !== 16'h0) $display("FAIL rst_addr: got %0h expected 0", o_dram_addr); else passes++;
        checks++; if (o_valid !== 1'b0) $display("FAIL rst_valid: got %0b expected 0", o_valid); else passes++;
        checks++; if (o_data !== 8'h0) $display("FAIL rst_data: got %0h expected 0", o_data); else passes++;
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_stream();
        run_readout(16'h0024, 16'd18, 0, 8'h00);
        checks++; if (obs_xfer != 18) $display("FAIL stream_count: got %0d expected 18", obs_xfer); else passes++;
        checks++; if (obs_done != 1) $display("FAIL stream_done_pulses: got %0d expected 1", obs_done); else passes++;
    endtask

    task automatic test_backpressure();
        run_readout(16'h0024, 16'd18, 1, 8'h00);
        checks++;
        if (obs_strobe_stall > int'(DEPTH))
            $display("FAIL stall_strobes: got %0d expected at most %0d", obs_strobe_stall, DEPTH);
        else passes++;
        checks++; if (obs_xfer != 18) $display("FAIL stall_count: got %0d expected 18", obs_xfer); else passes++;
        checks++; if (obs_done != 1) $display("FAIL stall_done_pulses: got %0d expected 1", obs_done); else passes++;
    endtask

    task automatic test_zero_count();
        int reads = 0;
        i_base_addr = 16'h0100; i_count = 16'd0; i_start = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        if (o_dram_read) reads++;
        checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b1)
            $display("FAIL zero_done: busy=%0b done=%0b expected 1 1", o_busy, o_done);
        else passes++;
        @(posedge i_clk); #1;
        if (o_dram_read) reads++;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0)
            $display("FAIL zero_after: busy=%0b done=%0b expected 0 0", o_busy, o_done);
        else passes++;
        @(posedge i_clk); #1;
        if (o_dram_read) reads++;
        checks++; if (reads != 0) $display("FAIL zero_reads: got %0d expected 0", reads); else passes++;
    endtask

    task automatic test_wrap();
        run_readout(16'hFFFE, 16'd4, 0, 8'hA5);
        checks++; if (obs_xfer != 4) $display("FAIL wrap_count: got %0d expected 4", obs_xfer); else passes++;
    endtask

    task automatic test_reset_abort();
        logic [15:0] a;
        logic [7:0]  d;
        int          xfer = 0;
        int          cyc = 0;
        for (int i = 0; i < 18; i++) begin
            a = 16'h0100 + 16'(i);
            exp_data_q.push_back(a[7:0] ^ 8'h0F);
        end
        dram_key = 8'h0F;
        i_base_addr = 16'h0100; i_count = 16'd18; i_start = 1'b1; i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        while (xfer < 5 && cyc < 200) begin
            if (o_valid && i_ready) begin
                xfer++;
                d = exp_data_q.pop_front();
                checks++;
                if (o_data !== d) $display("FAIL abort_data: got %0h expected %0h", o_data, d);
                else passes++;
            end
            if (xfer == 5) i_rst_n = 1'b0;
            @(posedge i_clk); #1;
            cyc++;
        end
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_dram_read !== 1'b0 ||
            o_dram_addr !== 16'h0 || o_valid !== 1'b0 || o_data !== 8'h0)
            $display("FAIL abort_outputs: busy=%0b done=%0b read=%0b addr=%0h valid=%0b data=%0h expected all 0",
                     o_busy, o_done, o_dram_read, o_dram_addr, o_valid, o_data);
        else passes++;
        i_rst_n = 1'b1;
        exp_data_q.delete();
        for (int k = 0; k < 4; k++) begin
            @(posedge i_clk); #1;
            checks++;
            if (o_valid !== 1'b0 || o_done !== 1'b0 || o_busy !== 1'b0)
                $display("FAIL abort_quiet: valid=%0b done=%0b busy=%0b expected 0 0 0", o_valid, o_done, o_busy);
            else passes++;
        end
        run_readout(16'h0200, 16'd6, 0, 8'h33);
        checks++; if (obs_xfer != 6) $display("FAIL restart_count: got %0d expected 6", obs_xfer); else passes++;
        checks++; if (obs_done != 1) $display("FAIL restart_done: got %0d expected 1", obs_done); else passes++;
    endtask

    task automatic test_random_ready();
        run_readout(16'h1230, 16'd64, 2, 8'h5A);
        checks++; if (obs_xfer != 64) $display("FAIL random_count: got %0d expected 64", obs_xfer); else passes++;
        checks++; if (obs_done != 1) $display("FAIL random_done_pulses: got %0d expected 1", obs_done); else passes++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_reset_abort();
        test_random_ready();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
